result_uart_tx: RTL and testbench
=================================

# result_uart_tx

Serial reporter that fills the unused UART transmit path on the DE1-SoC board top. When the accelerator run finishes, the board top pulses `send` with the latched return value and the execution cycle count. This block frames both values into a fixed byte packet and shifts it out on `uart_txd` as 8N1 asynchronous serial, so results can be logged on a host instead of read off the HEX displays.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2. The baud counter width is $clog2(CLKS_PER_BIT).
- `SYNC_BYTE`, default 8'hA5: first byte of every packet.

Ports:
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `send` input, 1 bit: one-cycle request; sampled only while idle.
- `return_val` input, 32 bits: accelerator result; captured on accepted `send`.
- `cycle_count` input, 32 bits: execution cycle count; captured on accepted `send`.
- `busy` output, 1 bit: high while a packet is in flight.
- `done` output, 1 bit: one-cycle pulse when the final stop bit completes.
- `uart_txd` output, 1 bit: serial line; idles high.

## Operation
- Packet byte order: `SYNC_BYTE`, `return_val[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`, `cycle_count[7:0]` … `[31:24]`. That is 9 bytes, or 10 bytes with the checksum enabled.
- Each byte is sent as a start bit (0), 8 data bits LSB first, and a stop bit (1). Bytes go back to back with no idle gap.
- State machine:
  - S_IDLE: `uart_txd`=1, `busy`=0. On `send`=1, load the 64-bit shift buffer, set byte index to 0 and go to S_START.
  - S_START: drive 0 for CLKS_PER_BIT cycles, then go to S_DATA.
  - S_DATA: drive the current bit for CLKS_PER_BIT cycles. After bit 7, go to S_STOP.
  - S_STOP: drive 1 for CLKS_PER_BIT cycles. If the byte index is the last byte, pulse `done` and go to S_IDLE. Otherwise increment the index and go to S_START.
- Inputs are captured only on acceptance. Changes to `return_val` or `cycle_count` during a packet have no effect.
- `send` while `busy`=1 is ignored. It is not queued.
- `send` on the same cycle `done` pulses is ignored. The block is in S_IDLE the next cycle, and `send` is accepted from then on.
- Reset state: S_IDLE, `uart_txd`=1, `busy`=0, `done`=0, counters 0.
- `reset_n` low mid-packet: the line returns high asynchronously and the packet is abandoned. No `done` pulse is produced.

## Timing
- An accepted `send` at cycle T gives `busy`=1 and `uart_txd`=0 (start bit) from T+1.
- Each bit lasts exactly CLKS_PER_BIT cycles. A byte lasts 10·CLKS_PER_BIT cycles.
- Packet duration N·10·CLKS_PER_BIT cycles, where N = 9 or 10.
- The `done` pulse is on the last cycle of the final stop bit. `busy` falls on the following cycle.
- `uart_txd` is driven from a register, so the line is glitch-free.

## Configuration
- `RESULT_UART_CHKSUM_EN`:
  - Defined: a 10th byte is appended, equal to the XOR of the 8 payload bytes (the sync byte is excluded).
  - Undefined: the packet is 9 bytes, and no checksum logic or byte-index state is generated for it.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold `reset_n`=0 → `uart_txd`=1, `busy`=0, `done`=0. Then release and wait 100 cycles with no `send` → outputs are unchanged.
- Basic packet: `send` with `return_val`=32'h0000002A, `cycle_count`=32'h00012345 → decoded bytes are A5 2A 00 00 00 45 23 01 00. `done` is asserted 360 cycles after `busy` rises (400 cycles with the checksum enabled). The checksum byte is 8'h4D.
- Bit timing: the start bit of the first byte is low for exactly 4 cycles beginning at T+1. Each stop bit is high for exactly 4 cycles, with no gap between bytes.
- Busy rejection: pulse `send` with new values at packet midpoint → the packet is unaltered, no second packet follows, and `busy` falls once.
- Boundary: `send` on the `done` cycle → ignored. `send` one cycle later → a new packet starts, with the start bit on the next cycle.
- Reset mid-packet: drop `reset_n` during byte 3 → `uart_txd`=1 immediately and no `done`. After release, `send` produces a full, correct packet.

Source files
------------

// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - frames return value and cycle count into an 8N1 UART packet
//
// Packet: SYNC_BYTE, return_val[7:0..31:24], cycle_count[7:0..31:24]
//         (+ XOR of the 8 payload bytes when RESULT_UART_CHKSUM_EN is defined).
//
// Ports:
//   clk          - rising-edge clock
//   reset_n      - asynchronous active-low reset
//   send         - one-cycle request, accepted only while idle
//   return_val   - accelerator result, captured on accepted send
//   cycle_count  - execution cycle count, captured on accepted send
//   busy         - high while a packet is in flight
//   done         - one-cycle pulse on the last cycle of the final stop bit
//   uart_txd     - registered serial line, idles high
//
// Optional feature macro: RESULT_UART_CHKSUM_EN
module result_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        send,
    input  logic [31:0] return_val,
    input  logic [31:0] cycle_count,
    output logic        busy,
    output logic        done,
    output logic        uart_txd
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef RESULT_UART_CHKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd9;
`else
    localparam logic [3:0] LAST_BYTE = 4'd8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic [2:0]       bit_idx, bit_next;
    logic [3:0]       byte_idx, byte_next;
    logic [63:0]      payload;
    logic             txd_r, txd_next;
    logic             load;
    logic             baud_end;
    logic [7:0]       cur_byte;

`ifdef RESULT_UART_CHKSUM_EN
    logic [7:0] chk_r;
    logic [7:0] chk_in;

    always_comb begin
        chk_in = 8'h00;
        for (int k = 0; k < 4; k++) begin
            chk_in = chk_in ^ return_val[8*k +: 8] ^ cycle_count[8*k +: 8];
        end
    end
`endif

    assign baud_end = (baud_cnt == BAUD_LAST);

    // Byte 0 is the sync byte, bytes 1..8 walk the captured payload LSB-first.
    always_comb begin
        cur_byte = SYNC_BYTE;
        for (int k = 1; k <= 8; k++) begin
            if (byte_idx == 4'(k)) cur_byte = payload[8*k-8 +: 8];
        end
`ifdef RESULT_UART_CHKSUM_EN
        if (byte_idx == 4'd9) cur_byte = chk_r;
`endif
    end

    // txd_next is the line value for the state being entered, so the
    // registered line changes on the same edge as the state.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + 1'b1;
        bit_next   = bit_idx;
        byte_next  = byte_idx;
        txd_next   = txd_r;
        load       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                baud_next = '0;
                txd_next  = 1'b1;
                if (send) begin
                    load       = 1'b1;
                    byte_next  = 4'd0;
                    bit_next   = 3'd0;
                    state_next = S_START;
                    txd_next   = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = S_DATA;
                    txd_next   = cur_byte[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        txd_next = cur_byte[bit_idx + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (byte_idx == LAST_BYTE) begin
                        done       = 1'b1;
                        state_next = S_IDLE;
                        txd_next   = 1'b1;
                    end else begin
                        byte_next  = byte_idx + 4'd1;
                        state_next = S_START;
                        txd_next   = 1'b0;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 4'd0;
            payload  <= 64'd0;
            txd_r    <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            byte_idx <= byte_next;
            txd_r    <= txd_next;
            if (load) payload <= {cycle_count, return_val};
        end
    end

`ifdef RESULT_UART_CHKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chk_r <= 8'h00;
        else if (load) chk_r <= chk_in;
    end
`endif

    assign busy     = (state != S_IDLE);
    assign uart_txd = txd_r;

endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - directed self-checking bench for result_uart_tx
module tb_result_uart_tx;

    localparam int CPB = 4;
`ifdef RESULT_UART_CHKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int PKT = NB * 10 * CPB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        send;
    logic [31:0] return_val;
    logic [31:0] cycle_count;
    logic        busy;
    logic        done;
    logic        uart_txd;

    int compared   = 0;
    int mismatched = 0;

    logic line_s [0:2047];
    logic busy_s [0:2047];
    logic done_s [0:2047];

    result_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .send(send),
        .return_val(return_val), .cycle_count(cycle_count),
        .busy(busy), .done(done), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] rv, input logic [31:0] cc);
        logic [63:0] p;
        logic [7:0]  x;
        p = {cc, rv};
        if (k == 0) return 8'hA5;
        if (k <= 8) return p[8*k-8 +: 8];
        x = 8'h00;
        for (int j = 0; j < 8; j++) x = x ^ p[8*j +: 8];
        return x;
    endfunction

    // Called #1 after an edge. Sample i is taken #1 after the i-th following edge.
    // During samples poke_idx..poke_idx+poke_len-1, send is driven high with new data.
    task automatic capture(input int ncyc, input int poke_idx, input int poke_len,
                           input logic [31:0] prv, input logic [31:0] pcc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            line_s[i] = uart_txd;
            busy_s[i] = busy;
            done_s[i] = done;
            if (i >= poke_idx && i < poke_idx + poke_len) begin
                send        = 1'b1;
                return_val  = prv;
                cycle_count = pcc;
            end else begin
                send = 1'b0;
            end
        end
    endtask

    task automatic start_packet(input logic [31:0] rv, input logic [31:0] cc);
        return_val  = rv;
        cycle_count = cc;
        send        = 1'b1;
    endtask

    task automatic check_packet(input int base, input logic [31:0] rv, input logic [31:0] cc,
                                input string tag);
        logic [7:0] d;
        logic       frame_ok;
        logic       busy_ok;
        int         ndone;
        for (int k = 0; k < NB; k++) begin
            int b0;
            b0 = base + k * 10 * CPB;
            frame_ok = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                if (line_s[b0 + c] !== 1'b0) frame_ok = 1'b0;
                if (line_s[b0 + 9 * CPB + c] !== 1'b1) frame_ok = 1'b0;
            end
            for (int b = 0; b < 8; b++) begin
                d[b] = line_s[b0 + (1 + b) * CPB];
                for (int c = 1; c < CPB; c++)
                    if (line_s[b0 + (1 + b) * CPB + c] !== d[b]) frame_ok = 1'b0;
            end
            chk($sformatf("%s_byte%0d", tag, k), 64'(d), 64'(exp_byte(k, rv, cc)));
            chk($sformatf("%s_frame%0d", tag, k), 64'(frame_ok), 64'd1);
        end
        ndone   = 0;
        busy_ok = 1'b1;
        for (int i = base; i < base + PKT; i++) begin
            if (done_s[i] === 1'b1) ndone++;
            if (busy_s[i] !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, "_done_last"}, 64'(done_s[base + PKT - 1]), 64'd1);
        chk({tag, "_done_count"}, 64'(ndone), 64'd1);
        chk({tag, "_busy_high"}, 64'(busy_ok), 64'd1);
        chk({tag, "_busy_fall"}, 64'(busy_s[base + PKT]), 64'd0);
    endtask

    task automatic check_idle(input int from, input int to, input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = from; i < to; i++)
            if (line_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || done_s[i] !== 1'b0) ok = 1'b0;
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        int nfall;
        reset_n     = 1'b0;
        send        = 1'b0;
        return_val  = 32'h0;
        cycle_count = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 64'(uart_txd), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        capture(100, -1, 0, 32'h0, 32'h0);
        check_idle(0, 100, "idle_100");

        // Basic packet
        start_packet(32'h0000002A, 32'h00012345);
        capture(PKT + 20, -1, 0, 32'h0, 32'h0);
        chk("basic_start_t1", 64'({line_s[0], busy_s[0]}), 64'b01);
        check_packet(0, 32'h0000002A, 32'h00012345, "basic");
        check_idle(PKT, PKT + 20, "basic_after");
`ifdef RESULT_UART_CHKSUM_EN
        chk("basic_chksum_const", 64'(exp_byte(9, 32'h0000002A, 32'h00012345)), 64'h4D);
`endif

        // Busy rejection: new send with new data at packet midpoint
        start_packet(32'h11223344, 32'h55667788);
        capture(2 * PKT, PKT / 2, 1, 32'hDEADBEEF, 32'hCAFEF00D);
        check_packet(0, 32'h11223344, 32'h55667788, "busyrej");
        check_idle(PKT, 2 * PKT, "busyrej_no_second");
        nfall = 0;
        for (int i = 1; i < 2 * PKT; i++)
            if (busy_s[i - 1] === 1'b1 && busy_s[i] === 1'b0) nfall++;
        chk("busyrej_one_fall", 64'(nfall), 64'd1);

        // Boundary: send on done cycle ignored, one cycle later accepted
        start_packet(32'hA1B2C3D4, 32'h0F1E2D3C);
        capture(2 * PKT + 10, PKT - 1, 2, 32'h87654321, 32'h00FF00FF);
        check_packet(0, 32'hA1B2C3D4, 32'h0F1E2D3C, "bnd_first");
        chk("bnd_idle_gap_txd", 64'(line_s[PKT]), 64'd1);
        chk("bnd_new_start", 64'({line_s[PKT + 1], busy_s[PKT + 1]}), 64'b01);
        check_packet(PKT + 1, 32'h87654321, 32'h00FF00FF, "bnd_second");

        // Reset mid-packet during byte 3 (a data bit that is 0 so the line is low)
        start_packet(32'h00000000, 32'h13579BDF);
        capture(3 * 10 * CPB + 6, -1, 0, 32'h0, 32'h0);
        chk("rstmid_line_low_before", 64'(uart_txd), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_txd", 64'(uart_txd), 64'd1);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        capture(20, -1, 0, 32'h0, 32'h0);
        check_idle(0, 20, "rstmid_no_done");
        start_packet(32'hFEDCBA98, 32'h76543210);
        capture(PKT + 5, -1, 0, 32'h0, 32'h0);
        check_packet(0, 32'hFEDCBA98, 32'h76543210, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
